i2c_lat_cmd_seq: RTL and testbench
==================================

Name: i2c_lat_cmd_seq

Overview:
- Upstream sequencer for the I2C master controller top. Drives that controller's register-style control interface from a simple command stream.
- Buffers write payload in a TX FIFO and read payload in an RX FIFO.
- Reports per-command completion and error status.
- Sits between the system/bus side and the controller; exactly one I2C transaction is in flight at a time.

Parameters:
- TX_DEPTH, 16, TX FIFO depth in bytes (power of 2, >=2)
- RX_DEPTH, 16, RX FIFO depth in bytes (power of 2, >=2)
- CLK_DIV, 8'd125, value driven on o_clk_div_lsb
- TIMEOUT, 100000, cycles without controller progress before abort (>=16)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_rw  in  1  1 = read, 0 = write
- cmd_addr  in  7  7-bit slave address
- cmd_len  in  8  byte count, 1..255
- tx_data  in  8  write payload byte
- tx_valid  in  1  payload byte offered
- tx_ready  out  1  TX FIFO not full
- rx_data  out  8  RX FIFO head
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop RX head when rx_valid
- busy  out  1  transaction in progress
- done  out  1  1-cycle pulse at end of every accepted command
- err  out  3  valid with done: [0] NACK, [1] TX underflow/RX overflow, [2] timeout
- o_slave_addr_reg  out  8  {1'b0, cmd_addr} latched
- o_byte_cnt_reg  out  8  cmd_len latched
- o_clk_div_lsb  out  8  CLK_DIV constant
- o_config_reg  out  8  bit0 = start request; other bits 0
- o_mode_reg  out  8  bit0 = rw latched; other bits 0
- i_cmd_status_reg  in  8  bit0 busy, bit6 ack error, bit7 transfer complete
- i_start_ack  in  1  controller accepted start
- o_transmit_data  out  8  TX FIFO head
- i_transmit_data_request  in  1  controller consumes o_transmit_data this cycle
- i_received_data_valid  in  1  i_receive_data valid this cycle
- i_receive_data  in  8  received byte
- i_int_n  in  1  active-low interrupt; not used for sequencing

Behaviour:
- Reset: all outputs 0 except o_clk_div_lsb = CLK_DIV. FIFOs empty, FSM IDLE, timeout counter 0. Reset mid-transaction abandons the transaction with no done pulse.
- FSM states: IDLE, ARM, START, XFER, FIN.
- IDLE: cmd_ready = 1.
  - cmd_len = 0: accept the command, assert no controller signal, pulse done next cycle with err = 0.
  - Otherwise latch addr/rw/len into the o_* registers and go to ARM.
- ARM:
  - Write: stay until TX FIFO count >= min(cmd_len, TX_DEPTH), then go to START.
  - Read: go to START immediately.
- START: o_config_reg[0] = 1 until the cycle i_start_ack = 1; next cycle drop to 0 and go to XFER.
- XFER:
  - On i_transmit_data_request, pop the TX FIFO. o_transmit_data is the combinational FIFO head. Request while the FIFO is empty sets sticky err[1] and pops nothing.
  - On i_received_data_valid, push i_receive_data. Push while the FIFO is full drops the byte and sets sticky err[1]. Simultaneous rx push and rx_ready pop on a full FIFO is legal and is not an overflow.
  - Exit to FIN on i_cmd_status_reg[7] = 1. err[0] is latched from i_cmd_status_reg[6].
- Timeout: counter clears on any of start_ack, data request, received valid, or state change; increments otherwise in START/XFER. Reaching TIMEOUT sets err[2] and forces FIN.
- FIN: done = 1 for one cycle with err, then clear err and return to IDLE. busy = 1 in ARM/START/XFER/FIN.
- TX FIFO accepts writes in every state, including prefetch for the next command. Leftover TX bytes after NACK are flushed in FIN.
- FIFO pointers: log2(depth)+1 bits with wrap bit; full = MSBs differ and LSBs equal.

Test Plan:
- Write addr 0x50, len 3, bytes A5,5A,FF preloaded -> o_slave_addr_reg = 0x50, o_byte_cnt_reg = 3, o_mode_reg = 0. Model sees A5,5A,FF on o_transmit_data at its 3 requests. done with err = 0.
- Read addr 0x48, len 4, model returns 11,22,33,44 -> rx_data pops 11,22,33,44 in order. done with err = 0. o_mode_reg[0] = 1 during transfer.
- Write len 2, model reports status bit6 = 1 then bit7 -> done with err = 3'b001. TX FIFO empty afterwards.
- Read len 20 with RX_DEPTH = 16 and rx_ready = 0 -> bytes 17..20 dropped, err = 3'b010, rx_valid stays high with first 16 bytes intact.
- Model never asserts i_start_ack, TIMEOUT = 100 -> done at START-entry + 100 cycles, err = 3'b100, o_config_reg = 0 afterwards.
- Assert rst during XFER of a read -> next cycle all outputs at reset values, rx_valid = 0, no done pulse. Next command runs normally.

Source files
------------

// File: rtl/i2c_lat_cmd_seq.sv
// i2c_lat_cmd_seq
// Upstream sequencer for the I2C master controller. It turns a simple command
// stream (rw/addr/len) into the controller's register-style control interface.
// Write payload is staged in a TX FIFO and read payload in an RX FIFO. Only one
// I2C transaction is in flight at a time.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_*                     command handshake (valid/ready), rw, 7-bit addr, len
//   tx_data/valid/ready       write payload into the TX FIFO (accepted in any state)
//   rx_data/valid/ready       read payload out of the RX FIFO
//   busy, done, err           status: done pulses once per accepted command,
//                             err = {timeout, underflow/overflow, nack} alongside done
//   o_slave_addr_reg, o_byte_cnt_reg, o_clk_div_lsb, o_config_reg, o_mode_reg
//                             register-style outputs to the controller
//   i_cmd_status_reg          controller status: [7] complete, [6] ack error
//   i_start_ack               controller accepted the start request
//   o_transmit_data, i_transmit_data_request   TX byte handoff
//   i_received_data_valid, i_receive_data      RX byte handoff
//   i_int_n                   interrupt, not used for sequencing
module i2c_lat_cmd_seq #(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16,
  parameter logic [7:0]  CLK_DIV  = 8'd125,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] err,
  output logic [7:0] o_slave_addr_reg,
  output logic [7:0] o_byte_cnt_reg,
  output logic [7:0] o_clk_div_lsb,
  output logic [7:0] o_config_reg,
  output logic [7:0] o_mode_reg,
  input  logic [7:0] i_cmd_status_reg,
  input  logic       i_start_ack,
  output logic [7:0] o_transmit_data,
  input  logic       i_transmit_data_request,
  input  logic       i_received_data_valid,
  input  logic [7:0] i_receive_data,
  input  logic       i_int_n
);

  localparam int unsigned TXW = $clog2(TX_DEPTH);
  localparam int unsigned RXW = $clog2(RX_DEPTH);
  localparam int unsigned TOW = $clog2(TIMEOUT);

  localparam logic [TXW:0]   TX_ONE     = {{TXW{1'b0}}, 1'b1};
  localparam logic [RXW:0]   RX_ONE     = {{RXW{1'b0}}, 1'b1};
  localparam logic [TOW-1:0] TO_ONE     = {{(TOW-1){1'b0}}, 1'b1};
  localparam logic [TOW-1:0] TO_LAST    = TOW'(TIMEOUT - 1);
  localparam logic [8:0]     TX_DEPTH_L = 9'(TX_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_XFER,
    S_FIN
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [TXW:0]   r_tx_wp, r_tx_rp;
  logic [RXW:0]   r_rx_wp, r_rx_rp;

  logic [TOW-1:0] r_to_cnt;
  logic [2:0]     r_err;
  logic           r_done;
  logic           r_cfg;
  logic [7:0]     r_addr;
  logic [7:0]     r_len;
  logic           r_rw;

  logic           w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic [TXW:0]   w_tx_count;
  logic [8:0]     w_tx_need;
  logic           w_tx_push, w_tx_req, w_tx_pop, w_tx_under, w_tx_flush;
  logic           w_rx_in, w_rx_push, w_rx_pop, w_rx_over;
  logic           w_cmd_acc, w_in_wait, w_progress, w_to_hit;
  logic           w_unused;

  // FIFO status: the extra pointer bit distinguishes full from empty
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[TXW] != r_tx_rp[TXW]) &&
                      (r_tx_wp[TXW-1:0] == r_tx_rp[TXW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[RXW] != r_rx_rp[RXW]) &&
                      (r_rx_wp[RXW-1:0] == r_rx_rp[RXW-1:0]);
  assign w_tx_count = r_tx_wp - r_tx_rp;

  // A write may start once the whole payload is staged, or the FIFO is full
  assign w_tx_need  = (9'(r_len) > TX_DEPTH_L) ? TX_DEPTH_L : 9'(r_len);

  assign w_tx_push  = tx_valid && tx_ready;
  assign w_tx_req   = (r_state == S_XFER) && i_transmit_data_request;
  assign w_tx_pop   = w_tx_req && !w_tx_empty;
  assign w_tx_under = w_tx_req && w_tx_empty;
  assign w_tx_flush = (r_state == S_FIN) && r_err[0];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then
  assign w_rx_pop   = rx_ready && !w_rx_empty;
  assign w_rx_in    = (r_state == S_XFER) && i_received_data_valid;
  assign w_rx_push  = w_rx_in && (!w_rx_full || w_rx_pop);
  assign w_rx_over  = w_rx_in && !w_rx_push;

  assign w_cmd_acc  = cmd_valid && cmd_ready;
  assign w_in_wait  = (r_state == S_START) || (r_state == S_XFER);
  assign w_progress = i_start_ack || i_transmit_data_request || i_received_data_valid;
  assign w_to_hit   = w_in_wait && !w_progress && (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_acc && (cmd_len != 8'd0)) w_state_nxt = S_ARM;
      S_ARM:   if (r_rw || (9'(w_tx_count) >= w_tx_need)) w_state_nxt = S_START;
      S_START: begin
        if (w_to_hit)         w_state_nxt = S_FIN;
        else if (i_start_ack) w_state_nxt = S_XFER;
      end
      S_XFER:  if (w_to_hit || i_cmd_status_reg[7]) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_to_cnt <= '0;
      r_err    <= '0;
      r_done   <= 1'b0;
      r_cfg    <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_rw     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Zero-length commands complete without touching the controller
      r_done  <= (w_state_nxt == S_FIN) || (w_cmd_acc && (cmd_len == 8'd0));
      // Start request is high for every START cycle, including the ack cycle
      r_cfg   <= (w_state_nxt == S_START);

      if (w_cmd_acc && (cmd_len != 8'd0)) begin
        r_addr <= {1'b0, cmd_addr};
        r_len  <= cmd_len;
        r_rw   <= cmd_rw;
      end

      if (w_progress || (w_state_nxt != r_state)) begin
        r_to_cnt <= '0;
      end else if (w_in_wait) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end

      // err holds through FIN so it is presented with done, then clears
      if (r_state == S_FIN) begin
        r_err <= '0;
      end else begin
        if (w_tx_under || w_rx_over)                         r_err[1] <= 1'b1;
        if ((r_state == S_XFER) && i_cmd_status_reg[6])      r_err[0] <= 1'b1;
        if (w_to_hit)                                        r_err[2] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TX_ONE;
      // After a NACK the unsent payload is discarded; a byte written this
      // same cycle lands at the old write pointer and survives the flush
      if (w_tx_flush)    r_tx_rp <= r_tx_wp;
      else if (w_tx_pop) r_tx_rp <= r_tx_rp + TX_ONE;
      if (w_rx_push) r_rx_wp <= r_rx_wp + RX_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TXW-1:0]] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp[RXW-1:0]] <= i_receive_data;
  end

  assign cmd_ready        = (r_state == S_IDLE) && !r_done && !rst;
  assign tx_ready         = !w_tx_full && !rst;
  assign rx_valid         = !w_rx_empty;
  assign rx_data          = w_rx_empty ? '0 : r_rx_mem[r_rx_rp[RXW-1:0]];
  assign o_transmit_data  = w_tx_empty ? '0 : r_tx_mem[r_tx_rp[TXW-1:0]];
  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;
  assign err              = r_err;
  assign o_slave_addr_reg = r_addr;
  assign o_byte_cnt_reg   = r_len;
  assign o_clk_div_lsb    = CLK_DIV;
  assign o_config_reg     = {7'b0, r_cfg};
  assign o_mode_reg       = {7'b0, r_rw};

  assign w_unused = ^{i_int_n, i_cmd_status_reg[5:0]};

endmodule

// File: tb/tb_i2c_lat_cmd_seq.sv
// Testbench for i2c_lat_cmd_seq: randomized and directed commands against an
// I2C-controller model; done/err and RX bytes are checked by a scoreboard monitor.
module tb_i2c_lat_cmd_seq;

  localparam int unsigned TXD  = 16;
  localparam int unsigned RXD  = 16;
  localparam int unsigned TO   = 100;
  localparam logic [7:0]  CDIV = 8'd125;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       busy, done;
  logic [2:0] err;
  logic [7:0] o_slave_addr_reg, o_byte_cnt_reg, o_clk_div_lsb, o_config_reg, o_mode_reg;
  logic [7:0] i_cmd_status_reg;
  logic       i_start_ack;
  logic [7:0] o_transmit_data;
  logic       i_transmit_data_request, i_received_data_valid;
  logic [7:0] i_receive_data;
  logic       i_int_n;

  always #5 clk = ~clk;

  i2c_lat_cmd_seq #(
    .TX_DEPTH(TXD),
    .RX_DEPTH(RXD),
    .CLK_DIV (CDIV),
    .TIMEOUT (TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .err(err),
    .o_slave_addr_reg(o_slave_addr_reg), .o_byte_cnt_reg(o_byte_cnt_reg),
    .o_clk_div_lsb(o_clk_div_lsb), .o_config_reg(o_config_reg), .o_mode_reg(o_mode_reg),
    .i_cmd_status_reg(i_cmd_status_reg), .i_start_ack(i_start_ack),
    .o_transmit_data(o_transmit_data),
    .i_transmit_data_request(i_transmit_data_request),
    .i_received_data_valid(i_received_data_valid), .i_receive_data(i_receive_data),
    .i_int_n(i_int_n)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rx_mode = 0;  // 0: never pop, 1: random pops, 2: always pop

  logic [2:0] exp_done_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] rx_src_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rx_mode == 0)      rx_ready = 1'b0;
    else if (rx_mode == 1) rx_ready = 1'($urandom_range(0, 1));
    else                   rx_ready = 1'b1;
  end

  // Scoreboard monitor: completion status and RX bytes in order
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_done_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else                        check("done_err", 32'(err), 32'(exp_done_q.pop_front()));
    end
    if (!rst && rx_valid && rx_ready) begin
      if (exp_rx_q.size() == 0) check("unexpected_rx", 32'(rx_valid), 32'd0);
      else                      check("rx_byte", 32'(rx_data), 32'(exp_rx_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Error status a command should end with, from the planned controller behaviour
  function automatic logic [2:0] exp_err(input bit nack, input bit ovf, input bit tmo);
    return {tmo, ovf, nack};
  endfunction

  task automatic push_tx(input logic [7:0] b);
    int w;
    tx_data  = b;
    tx_valid = 1'b1;
    w = 0;
    while (!tx_ready && w < 50) begin tick(); w++; end
    check("tx_ready", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
    exp_tx_q.push_back(b);
  endtask

  task automatic issue_cmd(input logic rw, input logic [6:0] addr, input int len, input logic [2:0] e);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    exp_done_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start();
    int w;
    w = 0;
    while (!o_config_reg[0] && w < 100) begin tick(); w++; end
    check("start_req", 32'(o_config_reg), 32'd1);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 50) begin tick(); w++; end
    check("idle", 32'(busy), 32'd0);
  endtask

  // Controller model: accept start, move nxfer bytes, optional NACK, then complete
  task automatic ctrl(input logic rw, input logic [6:0] addr, input int len,
                      input bit nack, input int nxfer, input int keep);
    logic [7:0] b;
    wait_start();
    check("slave_addr", 32'(o_slave_addr_reg), 32'({1'b0, addr}));
    check("byte_cnt",   32'(o_byte_cnt_reg),   32'(len));
    check("mode",       32'(o_mode_reg),       32'(rw));
    i_start_ack = 1'b1;
    tick();
    i_start_ack = 1'b0;
    check("start_drop", 32'(o_config_reg), 32'd0);
    check("busy_xfer",  32'(busy), 32'd1);
    for (int i = 0; i < nxfer; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (!rw) begin
        b = exp_tx_q.pop_front();
        check("tx_byte", 32'(o_transmit_data), 32'(b));
        i_transmit_data_request = 1'b1;
        tick();
        i_transmit_data_request = 1'b0;
      end else begin
        b = rx_src_q.pop_front();
        if (i < keep) exp_rx_q.push_back(b);
        i_receive_data        = b;
        i_received_data_valid = 1'b1;
        tick();
        i_received_data_valid = 1'b0;
      end
    end
    if (nack) begin
      i_cmd_status_reg = 8'h40;
      tick();
      i_cmd_status_reg = 8'h00;
      tick();
    end
    i_cmd_status_reg = 8'h80;
    tick();
    i_cmd_status_reg = 8'h00;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input bit in_rst);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_err",      32'(err), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data), 32'd0);
    check("rst_addr",     32'(o_slave_addr_reg), 32'd0);
    check("rst_cnt",      32'(o_byte_cnt_reg), 32'd0);
    check("rst_cfg",      32'(o_config_reg), 32'd0);
    check("rst_mode",     32'(o_mode_reg), 32'd0);
    check("rst_txd",      32'(o_transmit_data), 32'd0);
    check("rst_clkdiv",   32'(o_clk_div_lsb), 32'(CDIV));
    if (in_rst) begin
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_tx_ready",  32'(tx_ready), 32'd0);
    end
  endtask

  initial begin
    int c0, c1, w, len;
    logic       rw;
    logic [6:0] addr;

    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
    tx_data = '0; tx_valid = 1'b0; i_cmd_status_reg = '0; i_start_ack = 1'b0;
    i_transmit_data_request = 1'b0; i_received_data_valid = 1'b0;
    i_receive_data = '0; i_int_n = 1'b1;
    repeat (3) tick();
    check_reset_outputs(1'b1);
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_tx_ready",  32'(tx_ready), 32'd1);

    // Write 0x50, A5 5A FF preloaded
    push_tx(8'hA5); push_tx(8'h5A); push_tx(8'hFF);
    issue_cmd(1'b0, 7'h50, 3, exp_err(0, 0, 0));
    ctrl(1'b0, 7'h50, 3, 0, 3, 0);

    // Read 0x48, 11 22 33 44 with random pops
    rx_mode = 1;
    rx_src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue_cmd(1'b1, 7'h48, 4, exp_err(0, 0, 0));
    ctrl(1'b1, 7'h48, 4, 0, 4, 4);
    rx_mode = 2;
    repeat (6) tick();
    check("rx_drained", 32'(exp_rx_q.size()), 32'd0);

    // NACK on a two-byte write: leftover payload is discarded
    addr = 7'($urandom);
    push_tx(8'($urandom_range(1, 255))); push_tx(8'($urandom_range(1, 255)));
    issue_cmd(1'b0, addr, 2, exp_err(1, 0, 0));
    ctrl(1'b0, addr, 2, 1, 0, 0);
    check("tx_flushed", 32'(o_transmit_data), 32'd0);
    exp_tx_q.delete();
    push_tx(8'h3C);
    issue_cmd(1'b0, addr, 1, exp_err(0, 0, 0));
    ctrl(1'b0, addr, 1, 0, 1, 0);

    // Read 20 into a 16-deep RX FIFO with no pops: last 4 dropped
    rx_mode = 0;
    repeat (2) tick();
    for (int i = 0; i < 20; i++) rx_src_q.push_back(8'($urandom));
    addr = 7'($urandom);
    issue_cmd(1'b1, addr, 20, exp_err(0, 1, 0));
    ctrl(1'b1, addr, 20, 0, 20, RXD);
    check("ovf_rx_valid", 32'(rx_valid), 32'd1);
    rx_mode = 2;
    repeat (20) tick();
    check("ovf_rx_empty", 32'(rx_valid), 32'd0);
    check("ovf_rx_all", 32'(exp_rx_q.size()), 32'd0);

    // Start never acknowledged: timeout TO cycles after entering START
    issue_cmd(1'b1, 7'h21, 1, exp_err(0, 0, 1));
    wait_start();
    c0 = cyc;
    w = 0;
    while (!done && w < 300) begin tick(); w++; end
    c1 = cyc;
    check("timeout_cycles", 32'(c1 - c0), 32'(TO));
    tick();
    check("timeout_cfg", 32'(o_config_reg), 32'd0);
    wait_idle();

    // Reset in the middle of a read transfer
    rx_mode = 0;
    issue_cmd(1'b1, 7'h33, 4, 3'b000);
    wait_start();
    i_start_ack = 1'b1; tick(); i_start_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_receive_data = 8'($urandom); i_received_data_valid = 1'b1; tick();
      i_received_data_valid = 1'b0;
    end
    rst = 1'b1;
    exp_done_q.delete();
    tick();
    check_reset_outputs(1'b1);
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_done", 32'(done), 32'd0);
    rx_mode = 1;
    rx_src_q = '{8'h5E, 8'hA1, 8'h07};
    issue_cmd(1'b1, 7'h33, 3, exp_err(0, 0, 0));
    ctrl(1'b1, 7'h33, 3, 0, 3, 3);

    // Zero-length command: done with no controller activity
    issue_cmd(1'b0, 7'h11, 0, exp_err(0, 0, 0));
    check("len0_cfg",  32'(o_config_reg), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    tick();

    // Random commands
    for (int n = 0; n < 8; n++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = 7'($urandom);
      len  = $urandom_range(1, 8);
      if (!rw) begin
        for (int i = 0; i < len; i++) push_tx(8'($urandom));
      end else begin
        for (int i = 0; i < len; i++) rx_src_q.push_back(8'($urandom));
      end
      issue_cmd(rw, addr, len, exp_err(0, 0, 0));
      ctrl(rw, addr, len, 0, len, len);
    end

    rx_mode = 2;
    repeat (20) tick();
    check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
    check("rx_q_empty",   32'(exp_rx_q.size()), 32'd0);
    check("final_idle",   32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
